// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronizes and latches interrupt sources, then priority-encodes them into one
// request/ack/done handshake toward the core, with a small register window on the data bus.
module irq_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IRQ-1:0]         irq_src_i,
    output logic                       irq_o,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id_o,
    input  logic                       irq_ack_i,
    input  logic                       irq_done_i,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [1:0]                 addr_i,
    input  logic [31:0]                wdata_i,
    output logic [31:0]                rdata_o,
    output logic                       rvalid_o
);
    localparam int ID_W = $clog2(NUM_IRQ);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] s, s_d, rise, pending, enable, mode, active, clr, ack_mask;
    logic [ID_W-1:0] top;
    logic wr;
    logic [31:0] rd;
    assign s        = sync[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign active   = pending & enable;
    assign wr       = req_i & we_i;
    assign ack_mask = (state == REQ && irq_ack_i) ? NUM_IRQ'(1) << irq_id_o : '0;
    assign clr      = ((wr && addr_i == 2'd0) ? wdata_i[NUM_IRQ-1:0] : '0) | ack_mask;
    assign rd       = addr_i == 2'd0 ? 32'(pending) :
                      addr_i == 2'd1 ? 32'(enable)  :
                      addr_i == 2'd2 ? 32'(mode)    :
                      ({14'd0, state, 16'd0} | 32'(irq_id_o));
    if (NUM_IRQ < 32) begin : g_hi
        logic unused_wdata;
        assign unused_wdata = ^wdata_i[31:NUM_IRQ];
    end
    // Scan downward so the lowest active index is the last one assigned
    always_comb begin
        top = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (active[i]) top = ID_W'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            s_d      <= '0;
            pending  <= '0;
            enable   <= '0;
            mode     <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], irq_src_i};
            s_d      <= s;
            // Edge bits: a new rise beats any clear on the same edge; level bits track s
            pending  <= (mode & (rise | (pending & ~clr))) | (~mode & s);
            if (wr && addr_i == 2'd1) enable <= wdata_i[NUM_IRQ-1:0];
            if (wr && addr_i == 2'd2) mode <= wdata_i[NUM_IRQ-1:0];
            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? rd : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else begin
            case (state)
                IDLE: if (|active) begin
                    state    <= REQ;
                    irq_o    <= 1'b1;
                    irq_id_o <= top;
                end
                REQ: if (irq_ack_i || !active[irq_id_o]) begin
                    state <= irq_ack_i ? SERVICE : IDLE;
                    irq_o <= 1'b0;
                end
                SERVICE: if (irq_done_i) state <= IDLE;
                default: begin
                    state <= IDLE;
                    irq_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus a randomized run, every cycle checked against a behavioural model.
module tb_irq_ctrl;
    localparam int N = 8, S = 2, IW = $clog2(N);
    logic clk = 0, rst = 1;
    logic [N-1:0] src = '0;
    logic ack = 0, done = 0, req = 0, we = 0;
    logic [1:0] addr = '0;
    logic [31:0] wdata = '0;
    logic irq, rvalid;
    logic [IW-1:0] id;
    logic [31:0] rdata, d;
    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .irq_src_i(src), .irq_o(irq), .irq_id_o(id),
        .irq_ack_i(ack), .irq_done_i(done), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid)
    );

    // Reference model: src history stands in for the synchronizer, phase 0/1/2 = idle/request/service
    logic [N-1:0] hist [S+1];
    logic [N-1:0] m_pend, m_en, m_mode;
    int m_phase, m_id;
    logic [31:0] m_rdata;
    logic m_rvalid;

    task automatic model_edge();
        logic [N-1:0] sv, sd, act, clrm, np;
        int nphase, nid;
        if (rst) begin
            for (int i = 0; i <= S; i++) hist[i] = '0;
            m_pend = '0; m_en = '0; m_mode = '0;
            m_phase = 0; m_id = 0; m_rdata = '0; m_rvalid = 0;
            return;
        end
        sv = hist[S-1];
        sd = hist[S];
        act = m_pend & m_en;
        m_rvalid = req;
        m_rdata = '0;
        if (req && !we)
            case (addr)
                2'd0: m_rdata = 32'(m_pend);
                2'd1: m_rdata = 32'(m_en);
                2'd2: m_rdata = 32'(m_mode);
                default: m_rdata = (m_phase * 65536) + m_id;
            endcase
        clrm = '0;
        if (req && we && addr == 2'd0) clrm = wdata[N-1:0];
        if (m_phase == 1 && ack) clrm[m_id] = 1'b1;
        np = m_pend;
        for (int k = 0; k < N; k++) begin
            if (!m_mode[k]) np[k] = sv[k];
            else if (sv[k] && !sd[k]) np[k] = 1'b1;
            else if (clrm[k]) np[k] = 1'b0;
        end
        nphase = m_phase;
        nid = m_id;
        if (m_phase == 0 && act != 0) begin
            nphase = 1;
            for (int k = N - 1; k >= 0; k--) if (act[k]) nid = k;
        end else if (m_phase == 1) begin
            if (ack) nphase = 2;
            else if (!act[m_id]) nphase = 0;
        end else if (m_phase == 2 && done) nphase = 0;
        if (req && we && addr == 2'd1) m_en = wdata[N-1:0];
        if (req && we && addr == 2'd2) m_mode = wdata[N-1:0];
        m_pend = np;
        m_phase = nphase;
        m_id = nid;
        for (int i = S; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = src;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_irq", 32'(irq), 32'(m_phase == 1));
        chk("m_id", 32'(id), 32'(m_id));
        chk("m_rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("m_rdata", rdata, m_rdata);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] v);
        req = 1; we = 1; addr = a; wdata = v;
        cycle();
        req = 0; we = 0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] v);
        req = 1; we = 0; addr = a;
        cycle();
        v = rdata;
        chk("rvalid_after_req", 32'(rvalid), 1);
        req = 0;
    endtask

    initial begin
        for (int i = 0; i <= S; i++) hist[i] = '0;
        m_pend = '0; m_en = '0; m_mode = '0; m_phase = 0; m_id = 0; m_rdata = '0; m_rvalid = 0;
        // Reset with sources toggling
        rst = 1;
        for (int i = 0; i < 5; i++) begin
            src = N'($urandom);
            cycle();
            chk("rst_irq", 32'(irq), 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_rvalid", 32'(rvalid), 0);
        end
        src = '0;
        cycle();
        rst = 0;
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a), d);
            chk("rst_reg", d, 0);
        end
        // Edge latency and handshake on source 2
        bus_wr(2'd1, 32'h04);
        bus_wr(2'd2, 32'h04);
        src = 8'h04;
        cycle();
        src = '0;
        repeat (S) cycle();
        chk("lat_early_irq", 32'(irq), 0);
        cycle();
        chk("lat_irq", 32'(irq), 1);
        chk("lat_id", 32'(id), 2);
        ack = 1; cycle(); ack = 0;
        chk("ack_irq_low", 32'(irq), 0);
        bus_rd(2'd0, d);
        chk("ack_pending", d, 32'h00);
        bus_rd(2'd3, d);
        chk("ack_status", d, 32'h0002_0002);
        done = 1; cycle(); done = 0;
        bus_rd(2'd3, d);
        chk("done_status", d, 32'h0000_0002);
        // Priority: 5 and 1 together
        bus_wr(2'd1, 32'hFF);
        bus_wr(2'd2, 32'hFF);
        src = 8'h22;
        cycle();
        src = '0;
        repeat (S + 1) cycle();
        chk("prio_irq", 32'(irq), 1);
        chk("prio_id", 32'(id), 1);
        ack = 1; cycle(); ack = 0;
        done = 1; cycle(); done = 0;
        chk("prio_idle_irq", 32'(irq), 0);
        cycle();
        chk("prio_next_irq", 32'(irq), 1);
        chk("prio_next_id", 32'(id), 5);
        ack = 1; cycle(); ack = 0;
        done = 1; cycle(); done = 0;
        // Withdraw via W1C
        src = 8'h08;
        cycle();
        src = '0;
        repeat (S + 1) cycle();
        chk("wd_irq", 32'(irq), 1);
        chk("wd_id", 32'(id), 3);
        bus_wr(2'd0, 32'h08);
        chk("wd_irq_hold", 32'(irq), 1);
        cycle();
        chk("wd_irq_drop", 32'(irq), 0);
        bus_rd(2'd3, d);
        chk("wd_status", d, 32'h0000_0003);
        // W1C on the same edge as a rise on source 0
        src = 8'h01;
        cycle();
        src = '0;
        cycle();
        bus_wr(2'd0, 32'h01);
        bus_rd(2'd0, d);
        chk("sim_set_wins", d, 32'h01);
        chk("sim_irq", 32'(irq), 1);
        chk("sim_id", 32'(id), 0);
        bus_wr(2'd0, 32'h01);
        ack = 1; cycle(); ack = 0;
        bus_rd(2'd3, d);
        chk("sim_ack_over_wd", d, 32'h0002_0000);
        done = 1; cycle(); done = 0;
        // Level mode on source 7
        bus_wr(2'd2, 32'h00);
        src = 8'h80;
        for (int i = 0; i < 10 && !irq; i++) cycle();
        chk("lvl_irq", 32'(irq), 1);
        chk("lvl_id", 32'(id), 7);
        ack = 1; cycle(); ack = 0;
        bus_rd(2'd0, d);
        chk("lvl_pending_kept", d, 32'h80);
        done = 1; cycle(); done = 0;
        src = '0;
        bus_wr(2'd1, 32'hFFFF_FF5A);
        bus_rd(2'd1, d);
        chk("bus_enable", d, 32'h5A);
        cycle();
        chk("bus_rvalid_once", 32'(rvalid), 0);
        bus_wr(2'd2, 32'hFFFF_FF00);
        bus_rd(2'd2, d);
        chk("bus_hi_bits", d, 32'h00);
        // Randomized run, including a reset in the middle of traffic
        for (int i = 0; i < 800; i++) begin
            rst = (i == 400);
            if ($urandom_range(3) == 0) src = N'($urandom);
            ack = ($urandom_range(3) == 0);
            done = ($urandom_range(3) == 0);
            req = ($urandom_range(1) == 0);
            we = ($urandom_range(2) == 0);
            addr = 2'($urandom);
            wdata = $urandom;
            cycle();
        end
        rst = 0; ack = 0; done = 0; req = 0; we = 0;
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
